// File: rtl/pool_window_reducer.sv
// rtl/pool_window_reducer.sv - streaming max/min/saturating-sum window reducer
module pool_window_reducer #(
   parameter int DATA_W = 8,
   parameter int WINDOW = 6,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [CNT_W-1:0]  WIN_C    = CNT_W'(WINDOW);
   localparam logic [DATA_W-1:0] DATA_MAX = '1;

   localparam logic [1:0] MODE_MAX = 2'b00;
   localparam logic [1:0] MODE_MIN = 2'b01;
   localparam logic [1:0] MODE_SUM = 2'b10;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          mode_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [CNT_W-1:0]    out_count_q;

   logic                first;
   logic                accept;
   logic                take;
   logic                close;
   logic [CNT_W-1:0]    cnt_inc;
   logic [DATA_W:0]     sum_wide;
   logic [DATA_W-1:0]   fold_val;

   assign out_data  = out_data_q;
   assign out_count = out_count_q;

   assign first   = (cnt_q == '0);
   assign cnt_inc = cnt_q + 1'b1;
   assign accept  = in_valid && in_ready;
   assign take    = out_valid && out_ready;
   // A window ends at the full count or on an early in_last, whichever is first.
   assign close   = accept && ((cnt_inc == WIN_C) || in_last);

   // Fold the incoming sample into the running value using the window's latched mode.
   always_comb begin
      sum_wide = {1'b0, acc_q} + {1'b0, in_data};
      fold_val = acc_q;
      if (first) begin
         fold_val = in_data;
      end else begin
         case (mode_q)
            MODE_MIN: fold_val = (in_data < acc_q) ? in_data : acc_q;
            MODE_SUM: fold_val = sum_wide[DATA_W] ? DATA_MAX : sum_wide[DATA_W-1:0];
            MODE_MAX: fold_val = (in_data > acc_q) ? in_data : acc_q;
            default:  fold_val = (in_data > acc_q) ? in_data : acc_q;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   // Next state and handshake outputs; handshakes depend only on the registered state.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (close) state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   // Accumulator, counter, mode latch and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= MODE_MAX;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else if (accept) begin
         if (first) mode_q <= mode;
         acc_q <= fold_val;
         if (close) begin
            out_data_q  <= fold_val;
            out_count_q <= cnt_inc;
            cnt_q       <= '0;
         end else begin
            cnt_q <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_pool_window_reducer.sv
// tb/tb_pool_window_reducer.sv - scoreboard bench for pool_window_reducer
module tb_pool_window_reducer;
   localparam int DATA_W = 8;
   localparam int WINDOW = 6;
   localparam int CNT_W  = 8;

   logic              clk = 0;
   logic              rst = 1;
   logic [1:0]        mode = 0;
   logic [DATA_W-1:0] in_data = 0;
   logic              in_valid = 0;
   logic              in_last = 0;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  out_count;
   logic              out_valid;
   logic              out_ready = 1;

   int checks = 0;
   int errors = 0;
   bit rand_rdy = 0;

   int   exp_data_q[$];
   int   exp_cnt_q[$];
   int   win_q[$];
   int   win_mode;

   pool_window_reducer #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: reduce a whole window from its sample list.
   function automatic int reduce(input int m, input int s[$]);
      int r = s[0];
      for (int i = 1; i < s.size(); i++) begin
         if (m == 1)      r = (s[i] < r) ? s[i] : r;
         else if (m == 2) r = r + s[i];
         else             r = (s[i] > r) ? s[i] : r;
      end
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic void model_accept(input int d, input bit last, input int m);
      if (win_q.size() == 0) win_mode = m;
      win_q.push_back(d);
      if (win_q.size() == WINDOW || last) begin
         exp_data_q.push_back(reduce(win_mode, win_q));
         exp_cnt_q.push_back(win_q.size());
         win_q.delete();
      end
   endfunction

   // Present one sample and hold it until accepted; called at posedge+1.
   task automatic send(input int d, input bit last, input int m);
      bit ok = 0;
      in_data = d; in_last = last; mode = m; in_valid = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=0 required=1");
      end else begin
         model_accept(d, last, m);
      end
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   // Monitor: compare each taken result against the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_data_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result actual=%0d required=none", out_data);
         end else begin
            check("out_data", out_data, exp_data_q.pop_front());
            check("out_count", out_count, exp_cnt_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      int a[$];
      int hd, hc;
      // Reset state
      rst = 1; idle(2); rst = 0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_count", out_count, 0);
      @(posedge clk); #1;

      // Max, full window, latency and single-cycle in_ready drop
      a = '{3, 9, 2, 9, 7, 1};
      foreach (a[i]) send(a[i], 0, 0);
      @(negedge clk);
      check("lat_out_valid", out_valid, 1);
      check("lat_in_ready_low", in_ready, 0);
      check("lat_out_data", out_data, 9);
      check("lat_out_count", out_count, 6);
      @(negedge clk);
      check("lat_in_ready_back", in_ready, 1);
      check("lat_out_valid_drop", out_valid, 0);
      @(posedge clk); #1;

      // Min, then mode switch mid-window is ignored
      a = '{200, 15, 40, 15, 99, 250};
      foreach (a[i]) send(a[i], 0, 1);
      a = '{50, 90, 30, 200, 70, 60};
      foreach (a[i]) send(a[i], 0, (i == 0) ? 1 : 0);

      // Sum with saturation, then unsaturated
      a = '{100, 100, 60, 0, 0, 0};
      foreach (a[i]) send(a[i], 0, 2);
      a = '{10, 20, 30, 1, 2, 3};
      foreach (a[i]) send(a[i], 0, 2);

      // Partial windows
      send(5, 0, 0); send(77, 1, 0);
      send(42, 1, 0);
      // Reserved mode acts as max
      a = '{4, 180, 3};
      foreach (a[i]) send(a[i], i == 2, 3);
      idle(3);

      // Backpressure
      out_ready = 0;
      a = '{11, 22, 33, 44, 55, 66};
      foreach (a[i]) send(a[i], 0, 2);
      @(negedge clk);
      hd = out_data; hc = out_count;
      check("bp_held_data", hd, 231);
      check("bp_held_count", hc, 6);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = i[0]; in_data = 8'hEE; in_last = 1;
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_data", out_data, hd);
         check("bp_out_count", out_count, hc);
      end
      @(posedge clk); #1;
      in_valid = 0; in_last = 0; out_ready = 1;
      a = '{8, 1, 250, 7, 0, 9};
      foreach (a[i]) send(a[i], 0, 0);
      idle(3);

      // Gaps then reset mid-window
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         send($urandom_range(0, 255), 0, 0);
      end
      rst = 1; @(posedge clk); #1; rst = 0;
      win_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_count", out_count, 0);
      @(posedge clk); #1;
      a = '{12, 14, 16, 18, 20, 22};
      foreach (a[i]) begin idle($urandom_range(0, 2)); send(a[i], 0, 2); end
      idle(3);

      // Randomized windows with random backpressure
      rand_rdy = 1;
      for (int n = 0; n < 300; n++) begin
         idle($urandom_range(0, 2));
         send($urandom_range(0, 255), ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
      end
      rand_rdy = 0;
      @(posedge clk); #1; out_ready = 1;
      for (int i = 0; i < 8; i++) send($urandom_range(0, 255), i == 7, 2);

      for (int i = 0; i < 50 && exp_data_q.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_data_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
